// File: rtl/vga_timing_gen.sv
// Raster timing generator: pixel-strobe prescaler, h/v counters and registered sync/blank/strobe
// outputs decoded from the next-state counters so they line up with x/y in the same cycle.
module vga_timing_gen #(
   parameter int unsigned H_ACTIVE = 640,
   parameter int unsigned H_FP     = 16,
   parameter int unsigned H_SYNC   = 96,
   parameter int unsigned H_BP     = 48,
   parameter int unsigned V_ACTIVE = 480,
   parameter int unsigned V_FP     = 10,
   parameter int unsigned V_SYNC   = 2,
   parameter int unsigned V_BP     = 33,
   parameter int unsigned PIX_DIV  = 2,
   parameter bit          SYNC_POL = 1'b0
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        en_i,
   output logic        pix_ce_o,
   output logic        hsync_o,
   output logic        vsync_o,
   output logic        video_on_o,
   output logic [10:0] x_o,
   output logic [10:0] y_o,
   output logic        line_start_o,
   output logic        frame_start_o
);

   localparam int unsigned HTotal     = H_ACTIVE + H_FP + H_SYNC + H_BP;
   localparam int unsigned VTotal     = V_ACTIVE + V_FP + V_SYNC + V_BP;
   localparam int unsigned HSyncStart = H_ACTIVE + H_FP;
   localparam int unsigned HSyncEnd   = HSyncStart + H_SYNC;
   localparam int unsigned VSyncStart = V_ACTIVE + V_FP;
   localparam int unsigned VSyncEnd   = VSyncStart + V_SYNC;
   localparam int unsigned DivW       = (PIX_DIV > 1) ? $clog2(PIX_DIV) : 1;
   localparam logic [DivW-1:0] DivMax = DivW'(PIX_DIV - 1);

   logic [DivW-1:0] div_q, div_d;
   logic [10:0]     h_q, h_d, v_q, v_d;
   logic            pix_ce_q, pix_ce_d;
   logic            hsync_q, hsync_d;
   logic            vsync_q, vsync_d;
   logic            video_q, video_d;
   logic            line_q, line_d;
   logic            frame_q, frame_d;
   logic            step;

   // The step fires on the edge that ends the last prescaler phase; with en low the prescaler
   // position is held, so a pending step is neither lost nor repeated across a pause.
   always_comb begin
      div_d = div_q;
      h_d   = h_q;
      v_d   = v_q;
      step  = 1'b0;
      if (en_i) begin
         step  = (div_q == DivMax);
         div_d = step ? '0 : div_q + DivW'(1);
         if (step) begin
            if (h_q == 11'(HTotal - 1)) begin
               h_d = '0;
               v_d = (v_q == 11'(VTotal - 1)) ? '0 : v_q + 11'd1;
            end else begin
               h_d = h_q + 11'd1;
            end
         end
      end
   end

   always_comb begin
      pix_ce_d = en_i && (div_d == DivMax);
      hsync_d  = ((h_d >= 11'(HSyncStart)) && (h_d < 11'(HSyncEnd))) ? SYNC_POL : ~SYNC_POL;
      vsync_d  = ((v_d >= 11'(VSyncStart)) && (v_d < 11'(VSyncEnd))) ? SYNC_POL : ~SYNC_POL;
      video_d  = (h_d < 11'(H_ACTIVE)) && (v_d < 11'(V_ACTIVE));
      line_d   = step && (h_d == '0);
      frame_d  = step && (h_d == '0) && (v_d == '0);
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         div_q    <= '0;
         h_q      <= 11'(HTotal - 1);
         v_q      <= 11'(VTotal - 1);
         pix_ce_q <= 1'b0;
         hsync_q  <= ~SYNC_POL;
         vsync_q  <= ~SYNC_POL;
         video_q  <= 1'b0;
         line_q   <= 1'b0;
         frame_q  <= 1'b0;
      end else begin
         div_q    <= div_d;
         h_q      <= h_d;
         v_q      <= v_d;
         pix_ce_q <= pix_ce_d;
         hsync_q  <= hsync_d;
         vsync_q  <= vsync_d;
         video_q  <= video_d;
         line_q   <= line_d;
         frame_q  <= frame_d;
      end
   end

   assign pix_ce_o      = pix_ce_q;
   assign hsync_o       = hsync_q;
   assign vsync_o       = vsync_q;
   assign video_on_o    = video_q;
   assign x_o           = h_q;
   assign y_o           = v_q;
   assign line_start_o  = line_q;
   assign frame_start_o = frame_q;

endmodule
